// File: rtl/dmem_access_unit_pkg.sv
// Shared data-memory access codes and request metadata for the MEM-stage access unit.
package dmem_access_unit_pkg;

    localparam logic [2:0] DM_WORD          = 3'b000;
    localparam logic [2:0] DM_HALFWORD      = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNS  = 3'b010;
    localparam logic [2:0] DM_BYTE          = 3'b011;
    localparam logic [2:0] DM_BYTE_UNS      = 3'b100;

    typedef struct packed {
        logic       we;
        logic [2:0] dmtype;
        logic [1:0] off;
    } req_meta_t;

    function automatic logic is_half(input logic [2:0] t);
        return (t == DM_HALFWORD) || (t == DM_HALFWORD_UNS);
    endfunction

    function automatic logic is_byte(input logic [2:0] t);
        return (t == DM_BYTE) || (t == DM_BYTE_UNS);
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Pipeline-side request/response and data-memory bus of the MEM-stage access unit.
interface dmem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_dmtype;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_dmtype, req_addr, req_wdata, mem_ready, mem_rdata,
        output stall, rsp_valid, rsp_rdata, misalign, timeout,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_dmtype, req_addr, req_wdata, mem_ready, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, misalign, timeout,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/dmem_access_unit_lane_align.sv
// Byte-lane steering: store enables/replicated data, load extraction/extension, alignment check.
// Purely combinational, no backpressure.
module dm_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata,
    output logic        aligned
);
    logic [7:0]  byte_dat;
    logic [15:0] half_dat;

    assign byte_dat = rdata[{off, 3'b000} +: 8];
    assign half_dat = off[1] ? rdata[31:16] : rdata[15:0];

    // Unassigned codes fall through to word behaviour.
    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        ext_rdata  = rdata;
        aligned    = (off == 2'b00);
        if (is_half(dmtype)) begin
            be         = 4'b0011 << off;
            lane_wdata = {2{wdata[15:0]}};
            aligned    = ~off[0];
            ext_rdata  = (dmtype == DM_HALFWORD) ? {{16{half_dat[15]}}, half_dat}
                                                 : {16'h0000, half_dat};
        end else if (is_byte(dmtype)) begin
            be         = 4'b0001 << off;
            lane_wdata = {4{wdata[7:0]}};
            aligned    = 1'b1;
            ext_rdata  = (dmtype == DM_BYTE) ? {{24{byte_dat[7]}}, byte_dat}
                                             : {24'h000000, byte_dat};
        end
    end
endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access: aligned request to a ready-handshaked memory, extended load result.
// Latency >= 3 cycles (accept, access, done); stalls the pipeline while mem_ready is low, up to MAX_WAIT.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    req_meta_t   meta;
    logic [2:0]  la_dmtype;
    logic [1:0]  la_off;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;
    logic        la_aligned;
    logic        accept;
    logic        reject;
    logic        wait_expired;

    // One lane aligner serves both phases: request decode in IDLE, load extraction in ACCESS.
    assign la_dmtype = (state == ST_IDLE) ? bus.req_dmtype   : meta.dmtype;
    assign la_off    = (state == ST_IDLE) ? bus.req_addr[1:0] : meta.off;

    dm_lane_align u_lane_align (
        .dmtype     (la_dmtype),
        .off        (la_off),
        .wdata      (bus.req_wdata),
        .rdata      (bus.mem_rdata),
        .be         (la_be),
        .lane_wdata (la_wdata),
        .ext_rdata  (la_rdata),
        .aligned    (la_aligned)
    );

    assign accept       = (state == ST_IDLE) && bus.req_valid && la_aligned;
    assign reject       = (state == ST_IDLE) && bus.req_valid && !la_aligned;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
            ST_ACCESS: if (bus.mem_ready || wait_expired) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.stall = accept || (state == ST_ACCESS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt      <= '0;
            meta          <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.misalign  <= 1'b0;
            bus.timeout   <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.misalign  <= reject;
            bus.timeout   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            case (state)
                ST_IDLE: if (accept) begin
                    meta          <= '{we: bus.req_we, dmtype: bus.req_dmtype, off: bus.req_addr[1:0]};
                    wait_cnt      <= '0;
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= bus.req_we;
                    bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                    bus.mem_be    <= bus.req_we ? la_be : 4'b1111;
                    bus.mem_wdata <= la_wdata;
                end
                ST_ACCESS: begin
                    // Ready takes priority over an expiring wait counter.
                    if (bus.mem_ready || wait_expired) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= (bus.mem_ready && !meta.we) ? la_rdata : 32'h0;
                        bus.timeout   <= !bus.mem_ready;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_be    <= '0;
                        bus.mem_wdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed corner cases then randomized loads/stores against a lane model.
module tb_dmem_access_unit;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    dmem_access_unit_if bus ();

    dmem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, derived from the type code.
    function automatic int unsigned size_of(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] mask_of(input int unsigned sz);
        return (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    endfunction

    function automatic logic m_aligned(input logic [2:0] t, input logic [31:0] a);
        return (a % size_of(t)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] t, input logic [31:0] a);
        int unsigned sz = size_of(t);
        if (!we) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] wd);
        int unsigned sz = size_of(t);
        logic [31:0] mult = (sz == 4) ? 32'd1 : (sz == 2) ? 32'h0001_0001 : 32'h0101_0101;
        return (wd & mask_of(sz)) * mult;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        int unsigned sz   = size_of(t);
        logic [31:0] mask = mask_of(sz);
        logic [31:0] raw  = (rd >> (8 * (a % 4))) & mask;
        if ((t == 3'd1 || t == 3'd3) && raw[8 * sz - 1]) raw = raw | ~mask;
        return raw;
    endfunction

    // Starts just after a rising edge; returns just after a rising edge.
    // ready_delay >= MAX_WAIT means memory never answers.
    task automatic do_access(input logic we, input logic [2:0] t, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int ready_delay);
        logic        al = m_aligned(t, a);
        logic        got_ready = 1'b0;
        logic [31:0] exp_rd;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_dmtype = t;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.mem_ready  = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(bus.stall), 32'(al));
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        if (!al) begin
            bus.req_valid = 1'b0;
            @(negedge clk);
            chk("misalign_pulse", 32'(bus.misalign), 32'd1);
            chk("misalign_no_req", 32'(bus.mem_req), 32'd0);
            chk("misalign_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("misalign_clears", 32'(bus.misalign), 32'd0);
            @(posedge clk); #1;
            return;
        end
        for (int c = 0; c < int'(MAX_WAIT); c++) begin
            @(negedge clk);
            chk("acc_mem_req", 32'(bus.mem_req), 32'd1);
            chk("acc_stall", 32'(bus.stall), 32'd1);
            chk("acc_mem_we", 32'(bus.mem_we), 32'(we));
            chk("acc_mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            chk("acc_mem_be", 32'(bus.mem_be), 32'(m_be(we, t, a)));
            if (we) chk("acc_mem_wdata", bus.mem_wdata, m_wdata(t, wd));
            if (c == ready_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd;
                got_ready = 1'b1;
            end
            @(posedge clk); #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (got_ready) break;
        end
        exp_rd = (got_ready && !we) ? m_rdata(t, a, rd) : 32'h0;
        @(negedge clk);
        chk("done_stall", 32'(bus.stall), 32'd0);
        chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("done_rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("done_timeout", 32'(bus.timeout), 32'(!got_ready));
        chk("done_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_dmtype = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        do_access(1'b1, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        do_access(1'b0, 3'd3, 32'h103, 32'h0, 32'h8012_3456, 0);
        do_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h8012_3456, 1);
        do_access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0);
        do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'hABCD_0000, 2);
        do_access(1'b0, 3'd1, 32'h102, 32'h0, 32'hABCD_0000, 0);
        do_access(1'b0, 3'd0, 32'h101, 32'h0, 32'h0, 0);
        do_access(1'b0, 3'd1, 32'h103, 32'h0, 32'h0, 0);
        do_access(1'b0, 3'd0, 32'h200, 32'h0, 32'h5555_AAAA, 99);
        do_access(1'b0, 3'd0, 32'h204, 32'h0, 32'h1357_9BDF, int'(MAX_WAIT) - 1);
        do_access(1'b0, 3'd7, 32'h208, 32'h0, 32'hCAFE_F00D, 0);

        // Reset while the memory request is outstanding.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_dmtype = 3'd0;
        bus.req_addr   = 32'h300;
        bus.mem_ready  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        do_access(1'b0, 3'd0, 32'h304, 32'h0, 32'h0BAD_CAFE, 0);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 60; i++) begin
            int unsigned r = $urandom_range(0, 7);
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, $urandom, (r == 7) ? 9 : int'(r % 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
